// File: rtl/tx_burst_controller.sv
// 40 kHz transmitter drive clock plus burst/listen sequencer for ultrasonic pings.
// Define TX_BURST_COUNTER_EN to build the completed-burst counter; otherwise burst_count is 0.
module tx_burst_controller #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int TX_FREQ_HZ    = 40_000,
    parameter int BURST_CYCLES  = 8,
    parameter int LISTEN_CYCLES = 400
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        start,
    input  logic        repeat_en,
    input  logic        abort,
    output logic        clk_40khz,
    output logic        transmitter_on,
    output logic        listen_window,
    output logic        busy,
    output logic        done,
    output logic [15:0] burst_count
);
    localparam int HALF    = CLK_FREQ_HZ / (2 * TX_FREQ_HZ);
    localparam int DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MAX_CYC = (BURST_CYCLES > LISTEN_CYCLES) ? BURST_CYCLES : LISTEN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_BURST,
        S_LISTEN
    } state_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             clk40_q, clk40_d;
    logic             rise_tick;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tx_on_q, listen_q, done_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        div_d   = div_q + 1'b1;
        clk40_d = clk40_q;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            clk40_d = ~clk40_q;
        end
    end

    // The FSM advances only on edges that raise clk_40khz, keeping bursts whole-period.
    assign rise_tick = (div_q == DIV_LAST) && !clk40_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            div_q   <= '0;
            clk40_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            clk40_q <= clk40_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tx_on_q  <= 1'b0;
            listen_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                tx_on_q  <= 1'b0;
                listen_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_ARM;
                            cnt_q   <= '0;
                        end
                    end
                    S_ARM: begin
                        if (rise_tick) begin
                            state_q <= S_BURST;
                            cnt_q   <= '0;
                            tx_on_q <= 1'b1;
                        end
                    end
                    S_BURST: begin
                        if (rise_tick) begin
                            if (cnt_q == BURST_LAST) begin
                                state_q  <= S_LISTEN;
                                cnt_q    <= '0;
                                tx_on_q  <= 1'b0;
                                listen_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    S_LISTEN: begin
                        if (rise_tick) begin
                            if (cnt_q == LISTEN_LAST) begin
                                cnt_q    <= '0;
                                listen_q <= 1'b0;
                                done_q   <= 1'b1;
                                if (repeat_en) begin
                                    state_q <= S_BURST;
                                    tx_on_q <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TX_BURST_COUNTER_EN
    logic        burst_end;
    logic [15:0] bursts_q;

    assign burst_end = !abort && (state_q == S_BURST) && rise_tick && (cnt_q == BURST_LAST);

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            bursts_q <= '0;
        end else if (burst_end) begin
            bursts_q <= bursts_q + 16'd1;
        end
    end

    assign burst_count = bursts_q;
`else
    assign burst_count = '0;
`endif

    assign clk_40khz      = clk40_q;
    assign transmitter_on = tx_on_q;
    assign listen_window  = listen_q;
    assign done           = done_q;
    assign busy           = (state_q != S_IDLE);

endmodule
